fetch_entry_buffer: RTL and testbench

FETCH_ENTRY_BUFFER -- requirements
Module: fetch_entry_buffer

---
 rtl/ariane_pkg.sv | 16 +
 rtl/fetch_entry_buffer.sv | 70 +++++++
 tb/tb_fetch_entry_buffer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared frontend types: the fetch entry handed from the instruction frontend to decode.
package ariane_pkg;

    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] instruction;
        exception_t  ex;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_buffer.sv
// Small in-order buffer between the frontend and decode. Once an excepting entry
// is accepted, later entries are acknowledged but dropped until the next flush.
module fetch_entry_buffer
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  fetch_entry_t             fetch_entry_i,
    input  logic                     fetch_entry_valid_i,
    output logic                     fetch_entry_ready_o,
    output fetch_entry_t             fetch_entry_o,
    output logic                     fetch_entry_valid_o,
    input  logic                     fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0]   usage_o,
    output logic                     ex_pending_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]         usage_q;
    logic                     ex_pending_q;

    logic full, push, pop, store;

    // A transfer happens on a side only when valid and ready are both high in the same
    // cycle; ready_o never looks at ready_i, so a full buffer refuses even while draining.
    assign full                = (usage_q == CNT_W'(DEPTH));
    assign fetch_entry_ready_o = !full && !flush_i;
    assign push                = fetch_entry_valid_i && fetch_entry_ready_o;
    assign pop                 = fetch_entry_valid_o && fetch_entry_ready_i;
    assign store               = push && !ex_pending_q;

    assign fetch_entry_valid_o = (usage_q != '0);
    assign fetch_entry_o       = mem_q[rd_ptr_q];
    assign usage_o             = usage_q;
    assign ex_pending_o        = ex_pending_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            usage_q      <= '0;
            ex_pending_q <= 1'b0;
        end else if (flush_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            usage_q      <= '0;
            ex_pending_q <= 1'b0;
        end else begin
            if (store) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (store && !pop)      usage_q <= usage_q + CNT_W'(1);
            else if (!store && pop) usage_q <= usage_q - CNT_W'(1);
            // Only flush or reset may clear this, even after the excepting entry drains.
            if (push && fetch_entry_i.ex.valid) ex_pending_q <= 1'b1;
        end
    end

    // Payload storage carries no reset; valid is derived solely from usage_q.
    always_ff @(posedge clk_i) begin
        if (store) mem_q[wr_ptr_q] <= fetch_entry_i;
    end

endmodule

// File: tb/tb_fetch_entry_buffer.sv
// Bench for fetch_entry_buffer: directed vector table, hand sequences for wrap and
// async reset, then random traffic against a queue-based reference model.
module tb_fetch_entry_buffer;
    import ariane_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   flush_i = 1'b0;
    fetch_entry_t           fetch_entry_i = '0;
    logic                   fetch_entry_valid_i = 1'b0;
    logic                   fetch_entry_ready_o;
    fetch_entry_t           fetch_entry_o;
    logic                   fetch_entry_valid_o;
    logic                   fetch_entry_ready_i = 1'b0;
    logic [$clog2(DEPTH):0] usage_o;
    logic                   ex_pending_o;

    fetch_entry_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .fetch_entry_i       (fetch_entry_i),
        .fetch_entry_valid_i (fetch_entry_valid_i),
        .fetch_entry_ready_o (fetch_entry_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i),
        .usage_o             (usage_o),
        .ex_pending_o        (ex_pending_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    // reference model and scoreboard
    logic [ENTRY_W-1:0] exp_q[$];
    logic               mdl_ex_pending;
    int                 n_vec = 0;
    int                 n_err = 0;

    task automatic chk(input string name, input logic [ENTRY_W-1:0] act, input logic [ENTRY_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic fetch_entry_t mk(input logic [31:0] addr, input logic exv);
        fetch_entry_t e;
        e.address     = addr;
        e.instruction = addr ^ 32'hdead_beef;
        e.ex.cause    = exv ? 32'd1 : 32'd0;
        e.ex.tval     = exv ? addr : 32'd0;
        e.ex.valid    = exv;
        return e;
    endfunction

    // Compare DUT outputs with the model in the current cycle (inputs already applied).
    task automatic check_model();
        int unsigned sz;
        sz = exp_q.size();
        chk("mdl_ready_o", ENTRY_W'(fetch_entry_ready_o), ENTRY_W'((sz < DEPTH) && !flush_i));
        chk("mdl_valid_o", ENTRY_W'(fetch_entry_valid_o), ENTRY_W'(sz != 0));
        chk("mdl_usage",   ENTRY_W'(usage_o), ENTRY_W'(sz));
        chk("mdl_ex_pend", ENTRY_W'(ex_pending_o), ENTRY_W'(mdl_ex_pending));
        if (sz != 0) chk("mdl_head", ENTRY_W'(fetch_entry_o), exp_q[0]);
    endtask

    // Apply the handshake rules to the model, then let the clock edge happen.
    task automatic advance();
        logic acc, deq;
        if (flush_i) begin
            exp_q.delete();
            mdl_ex_pending = 1'b0;
        end else begin
            acc = fetch_entry_valid_i && (exp_q.size() < DEPTH);
            deq = fetch_entry_ready_i && (exp_q.size() != 0);
            if (deq) void'(exp_q.pop_front());
            if (acc && !mdl_ex_pending) exp_q.push_back(fetch_entry_i);
            if (acc && fetch_entry_i.ex.valid) mdl_ex_pending = 1'b1;
        end
        @(posedge clk_i);
    endtask

    // driver
    task automatic drive(input logic fl, input logic v, input fetch_entry_t e, input logic rdy);
        @(negedge clk_i);
        flush_i             = fl;
        fetch_entry_valid_i = v;
        fetch_entry_i       = e;
        fetch_entry_ready_i = rdy;
        #1;
    endtask

    typedef struct {
        logic        fl;
        logic        v;
        logic [31:0] addr;
        logic        exv;
        logic        rdy;
        logic        e_ready;
        logic        e_valid;
        int          e_usage;
        logic [31:0] e_head;
        logic        e_pend;
    } vec_t;

    vec_t tbl[18];

    initial begin
        // fill / full-with-pop / refill, flush at usage 3, exception drop, flush clears pending
        tbl[0]  = '{0,1,32'h100,0,0, 1,0,0,32'h0,  0};
        tbl[1]  = '{0,1,32'h104,0,0, 1,1,1,32'h100,0};
        tbl[2]  = '{0,1,32'h108,0,0, 1,1,2,32'h100,0};
        tbl[3]  = '{0,1,32'h10c,0,0, 1,1,3,32'h100,0};
        tbl[4]  = '{0,1,32'h110,0,0, 0,1,4,32'h100,0};
        tbl[5]  = '{0,1,32'h110,0,1, 0,1,4,32'h100,0};
        tbl[6]  = '{0,1,32'h110,0,0, 1,1,3,32'h104,0};
        tbl[7]  = '{0,0,32'h0,  0,0, 0,1,4,32'h104,0};
        tbl[8]  = '{0,0,32'h0,  0,1, 0,1,4,32'h104,0};
        tbl[9]  = '{1,1,32'h114,0,1, 0,1,3,32'h108,0};
        tbl[10] = '{0,0,32'h0,  0,0, 1,0,0,32'h0,  0};
        tbl[11] = '{0,1,32'h200,1,0, 1,0,0,32'h0,  0};
        tbl[12] = '{0,1,32'h204,0,0, 1,1,1,32'h200,1};
        tbl[13] = '{0,1,32'h208,0,0, 1,1,1,32'h200,1};
        tbl[14] = '{0,0,32'h0,  0,1, 1,1,1,32'h200,1};
        tbl[15] = '{0,0,32'h0,  0,0, 1,0,0,32'h0,  1};
        tbl[16] = '{1,0,32'h0,  0,0, 0,0,0,32'h0,  1};
        tbl[17] = '{0,0,32'h0,  0,0, 1,0,0,32'h0,  0};

        exp_q.delete();
        mdl_ex_pending = 1'b0;

        // reset state
        #12;
        chk("rst_valid_o", ENTRY_W'(fetch_entry_valid_o), '0);
        chk("rst_usage",   ENTRY_W'(usage_o), '0);
        chk("rst_ex_pend", ENTRY_W'(ex_pending_o), '0);
        chk("rst_ready_o", ENTRY_W'(fetch_entry_ready_o), ENTRY_W'(1));
        rst_ni = 1'b1;

        // directed table
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].fl, tbl[i].v, mk(tbl[i].addr, tbl[i].exv), tbl[i].rdy);
            chk($sformatf("tbl%0d_ready_o", i), ENTRY_W'(fetch_entry_ready_o), ENTRY_W'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_valid_o", i), ENTRY_W'(fetch_entry_valid_o), ENTRY_W'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_usage", i),   ENTRY_W'(usage_o), ENTRY_W'(tbl[i].e_usage));
            chk($sformatf("tbl%0d_ex_pend", i), ENTRY_W'(ex_pending_o), ENTRY_W'(tbl[i].e_pend));
            if (tbl[i].e_valid)
                chk($sformatf("tbl%0d_head", i), ENTRY_W'(fetch_entry_o.address), ENTRY_W'(tbl[i].e_head));
            check_model();
            advance();
        end

        // streaming through a pointer wrap: 10 entries, usage held at 1
        drive(1'b0, 1'b1, mk(32'h8000_0000, 1'b0), 1'b0);
        check_model();
        advance();
        for (int k = 1; k < 10; k++) begin
            drive(1'b0, 1'b1, mk(32'h8000_0000 + 32'(4 * k), 1'b0), 1'b1);
            chk($sformatf("wrap%0d_usage", k), ENTRY_W'(usage_o), ENTRY_W'(1));
            chk($sformatf("wrap%0d_head", k), ENTRY_W'(fetch_entry_o.address),
                ENTRY_W'(32'h8000_0000 + 32'(4 * (k - 1))));
            check_model();
            advance();
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("wrap_last_head", ENTRY_W'(fetch_entry_o.address), ENTRY_W'(32'h8000_0024));
        check_model();
        advance();

        // asynchronous reset at usage 2, mid-cycle
        drive(1'b0, 1'b1, mk(32'h300, 1'b0), 1'b0); check_model(); advance();
        drive(1'b0, 1'b1, mk(32'h304, 1'b1), 1'b0); check_model(); advance();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("pre_rst_usage", ENTRY_W'(usage_o), ENTRY_W'(2));
        rst_ni = 1'b0;
        #1;
        chk("async_rst_valid_o", ENTRY_W'(fetch_entry_valid_o), '0);
        chk("async_rst_usage",   ENTRY_W'(usage_o), '0);
        chk("async_rst_ex_pend", ENTRY_W'(ex_pending_o), '0);
        exp_q.delete();
        mdl_ex_pending = 1'b0;
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        drive(1'b0, 1'b1, mk(32'h400, 1'b0), 1'b0);
        chk("post_rst_ready_o", ENTRY_W'(fetch_entry_ready_o), ENTRY_W'(1));
        check_model();
        advance();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("post_rst_usage", ENTRY_W'(usage_o), ENTRY_W'(1));
        check_model();
        advance();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            fetch_entry_t e;
            e          = mk($urandom, ($urandom_range(0, 19) == 0));
            e.ex.cause = $urandom;
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), e,
                  ($urandom_range(0, 2) != 0));
            check_model();
            advance();
        end

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
